// File: rtl/clkdiv_pkg.sv
// Shared types, constants and helpers for the multi-channel clock divider.
// Optional feature macro: CLKDIV_PHASE_EN (per-channel start phase).
package clkdiv_pkg;

  // Widest supported divisor and channel index (up to 16 channels plus an
  // extra bit so an out-of-range index can still be represented).
  localparam int unsigned DIV_W_MAX = 16;
  localparam int unsigned CH_IDX_W  = 5;

  // Smallest divisor that produces a real divided wave; at or below it the
  // channel runs in bypass.
  localparam int unsigned DIV_MIN = 1;

  typedef logic [CH_IDX_W-1:0]  ch_idx_t;
  typedef logic [DIV_W_MAX-1:0] div_t;

  // Number of high cycles in one period.
  function automatic div_t half_period(input div_t d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/shadow divisor, pending flag
// and registered div_out / tick_out.
// Ports:
//   clk, rst (async active-low), en (run enable), wr (decoded divisor write),
//   wr_div (new divisor), wr_phase (CLKDIV_PHASE_EN only: start phase),
//   pending (shadow waiting to apply), div_out (square wave), tick_out (period strobe).
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0] wr_phase,
`endif
  output logic             pending,
  output logic             div_out,
  output logic             tick_out
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] shadow_div;

  logic             bypass_c;
  logic             wrap_c;
  logic             apply_c;
  logic [DIV_W-1:0] last_c;
  logic [DIV_W-1:0] half_c;
  logic [DIV_W-1:0] cur_c;

`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0] phase_sh;
  logic             en_q;
`endif

  // Period bookkeeping: where we are now and whether this edge ends a period.
  always_comb begin
    bypass_c = (active_div <= DIV_W'(DIV_MIN));
    last_c   = active_div - DIV_W'(1);
    half_c   = DIV_W'(half_period(div_t'(active_div)));
    cur_c    = cnt;
`ifdef CLKDIV_PHASE_EN
    // First enabled edge starts from the programmed phase (or 0 if out of range).
    if (!en_q) cur_c = (phase_sh < active_div) ? phase_sh : '0;
`endif
    wrap_c   = bypass_c || (cur_c == last_c);
    // Idle channels have no period in flight, so a shadow may apply any time.
    apply_c  = !en || wrap_c;
  end

  // Counter, outputs and divisor shadowing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      active_div <= DEF_DIV;
      shadow_div <= DEF_DIV;
      pending    <= 1'b0;
      div_out    <= 1'b0;
      tick_out   <= 1'b0;
    end else begin
      if (!en) begin
        cnt      <= '0;
        div_out  <= 1'b0;
        tick_out <= 1'b0;
      end else if (bypass_c) begin
        cnt      <= '0;
        div_out  <= 1'b1;
        tick_out <= 1'b1;
      end else begin
        cnt      <= wrap_c ? '0 : cur_c + DIV_W'(1);
        div_out  <= (cur_c < half_c);
        tick_out <= (cur_c == '0);
      end

      if (apply_c && pending) active_div <= shadow_div;

      // A write coinciding with an apply lets the old shadow go live and
      // keeps the new value pending for the next boundary.
      if (wr) begin
        shadow_div <= wr_div;
        pending    <= 1'b1;
      end else if (apply_c) begin
        pending    <= 1'b0;
      end
    end
  end

`ifdef CLKDIV_PHASE_EN
  // Phase shadow and enable history for the start-phase feature.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_sh <= '0;
      en_q     <= 1'b0;
    end else begin
      en_q <= en;
      if (wr) phase_sh <= wr_phase;
    end
  end
`endif

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel runtime-programmable clock divider with glitch-free divisor
// updates at period boundaries.
// Optional feature macro: CLKDIV_PHASE_EN adds cfg_phase and per-channel start phase.
// Ports:
//   clk, rst (async active-low), en[CHANNELS] run enables,
//   cfg_wr/cfg_ch/cfg_div (divisor write), cfg_phase (CLKDIV_PHASE_EN only),
//   cfg_ack / cfg_err (one-cycle write response), pending[CHANNELS],
//   div_out[CHANNELS], tick_out[CHANNELS].
module clk_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        en,
  input  logic                       cfg_wr,
  // One extra index bit so out-of-range channels are expressible and flagged.
  input  logic [$clog2(CHANNELS):0]  cfg_ch,
  input  logic [DIV_W-1:0]           cfg_div,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0]           cfg_phase,
`endif
  output logic                       cfg_ack,
  output logic                       cfg_err,
  output logic [CHANNELS-1:0]        pending,
  output logic [CHANNELS-1:0]        div_out,
  output logic [CHANNELS-1:0]        tick_out
);

  logic                in_range_c;
  logic [CHANNELS-1:0] wr_sel_c;

  // Channel decode; out-of-range writes select nothing.
  always_comb begin
    in_range_c = (ch_idx_t'(cfg_ch) < ch_idx_t'(CHANNELS));
    wr_sel_c   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel_c[i] = cfg_wr && in_range_c && (ch_idx_t'(cfg_ch) == ch_idx_t'(i));
    end
  end

  // Write response, registered on the same edge that captures the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_wr;
      cfg_err <= cfg_wr && !in_range_c;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[g]),
      .wr       (wr_sel_c[g]),
      .wr_div   (cfg_div),
`ifdef CLKDIV_PHASE_EN
      .wr_phase (cfg_phase),
`endif
      .pending  (pending[g]),
      .div_out  (div_out[g]),
      .tick_out (tick_out[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed self-checking bench for clk_divider_multi (CHANNELS=4, DIV_W=8, DEFAULT_DIV=2).
module tb_clk_divider_multi;

  logic       clk;
  logic       rst;
  logic [3:0] en;
  logic       cfg_wr;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_div;
`ifdef CLKDIV_PHASE_EN
  logic [7:0] cfg_phase;
`endif
  logic       cfg_ack;
  logic       cfg_err;
  logic [3:0] pending;
  logic [3:0] div_out;
  logic [3:0] tick_out;

  int errors = 0;
  int checks = 0;

  clk_divider_multi #(
    .CHANNELS    (4),
    .DIV_W       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
`ifdef CLKDIV_PHASE_EN
    .cfg_phase(cfg_phase),
`endif
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .pending  (pending),
    .div_out  (div_out),
    .tick_out (tick_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    en      = 4'b0000;
    cfg_wr  = 1'b0;
    cfg_ch  = 3'd0;
    cfg_div = 8'd0;
`ifdef CLKDIV_PHASE_EN
    cfg_phase = 8'd0;
`endif
    #12;
    chk("rst_div",  32'(div_out),  32'h0);
    chk("rst_tick", 32'(tick_out), 32'h0);
    chk("rst_pend", 32'(pending),  32'h0);
    chk("rst_ack",  32'(cfg_ack),  32'h0);
    chk("rst_err",  32'(cfg_err),  32'h0);

    // 1: ch0 with DEFAULT_DIV=2
    step();
    rst = 1'b1;
    en  = 4'b0001;
    step(); chk("t1_div_a", 32'(div_out), 32'h1); chk("t1_tick_a", 32'(tick_out), 32'h1);
    step(); chk("t1_div_b", 32'(div_out), 32'h0); chk("t1_tick_b", 32'(tick_out), 32'h0);
    step(); chk("t1_div_c", 32'(div_out), 32'h1); chk("t1_tick_c", 32'(tick_out), 32'h1);
    step(); chk("t1_div_d", 32'(div_out), 32'h0); chk("t1_tick_d", 32'(tick_out), 32'h0);

    // 2: ch1 div=5
    cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5;
    step();
    chk("t2_ack",  32'(cfg_ack), 32'h1);
    chk("t2_err",  32'(cfg_err), 32'h0);
    chk("t2_pend", 32'(pending), 32'h2);
    cfg_wr = 1'b0;
    step();
    chk("t2_ack_off",  32'(cfg_ack), 32'h0);
    chk("t2_pend_off", 32'(pending), 32'h0);
    en = 4'b0011;
    step(); chk("t2_div0", 32'(div_out[1]), 32'h1); chk("t2_tick0", 32'(tick_out[1]), 32'h1);
    step(); chk("t2_div1", 32'(div_out[1]), 32'h1); chk("t2_tick1", 32'(tick_out[1]), 32'h0);
    step(); chk("t2_div2", 32'(div_out[1]), 32'h0); chk("t2_tick2", 32'(tick_out[1]), 32'h0);
    step(); chk("t2_div3", 32'(div_out[1]), 32'h0); chk("t2_tick3", 32'(tick_out[1]), 32'h0);
    step(); chk("t2_div4", 32'(div_out[1]), 32'h0); chk("t2_tick4", 32'(tick_out[1]), 32'h0);
    step(); chk("t2_div5", 32'(div_out[1]), 32'h1); chk("t2_tick5", 32'(tick_out[1]), 32'h1);

    // 3: ch0 D=4, then write 3 mid-period
    en = 4'b0000;
    cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd4;
    step(); chk("t3_pend_w", 32'(pending), 32'h1);
    cfg_wr = 1'b0;
    step(); chk("t3_pend_a", 32'(pending), 32'h0);
    en = 4'b0001;
    step(); chk("t3_div_e1", 32'(div_out), 32'h1); chk("t3_tick_e1", 32'(tick_out), 32'h1);
    cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd3;
    step(); chk("t3_div_e2", 32'(div_out), 32'h1); chk("t3_tick_e2", 32'(tick_out), 32'h0);
    chk("t3_pend_e2", 32'(pending), 32'h1);
    cfg_wr = 1'b0;
    step(); chk("t3_div_e3", 32'(div_out), 32'h0); chk("t3_pend_e3", 32'(pending), 32'h1);
    step(); chk("t3_div_e4", 32'(div_out), 32'h0); chk("t3_pend_e4", 32'(pending), 32'h0);
    step(); chk("t3_div_e5", 32'(div_out), 32'h1); chk("t3_tick_e5", 32'(tick_out), 32'h1);
    step(); chk("t3_div_e6", 32'(div_out), 32'h0); chk("t3_tick_e6", 32'(tick_out), 32'h0);
    step(); chk("t3_div_e7", 32'(div_out), 32'h0); chk("t3_tick_e7", 32'(tick_out), 32'h0);
    step(); chk("t3_div_e8", 32'(div_out), 32'h1); chk("t3_tick_e8", 32'(tick_out), 32'h1);

    // 4: out-of-range channel writes
    cfg_wr = 1'b1; cfg_ch = 3'd7; cfg_div = 8'd9;
    step();
    chk("t4_ack7",  32'(cfg_ack), 32'h1);
    chk("t4_err7",  32'(cfg_err), 32'h1);
    chk("t4_pend7", 32'(pending), 32'h0);
    chk("t4_div7",  32'(div_out), 32'h0);
    cfg_ch = 3'd4;
    step();
    chk("t4_ack4",  32'(cfg_ack), 32'h1);
    chk("t4_err4",  32'(cfg_err), 32'h1);
    chk("t4_pend4", 32'(pending), 32'h0);
    chk("t4_div4",  32'(div_out), 32'h0);
    cfg_wr = 1'b0;
    step();
    chk("t4_ack_off", 32'(cfg_ack), 32'h0);
    chk("t4_err_off", 32'(cfg_err), 32'h0);
    chk("t4_div_p",   32'(div_out), 32'h1);
    chk("t4_tick_p",  32'(tick_out), 32'h1);
    step(); chk("t4_div_q", 32'(div_out), 32'h0);

    // 5: ch2 div=0 and ch3 div=1 both bypass
    en = 4'b0000;
    cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd0;
    step(); chk("t5_pend_a", 32'(pending), 32'h4);
    cfg_ch = 3'd3; cfg_div = 8'd1;
    step(); chk("t5_pend_b", 32'(pending), 32'h8);
    cfg_wr = 1'b0;
    step(); chk("t5_pend_c", 32'(pending), 32'h0);
    en = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_div",  32'(div_out),  32'hC);
      chk("t5_tick", 32'(tick_out), 32'hC);
    end

    // 6: reset mid-period on ch2
    en = 4'b0000;
    cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd6;
    step(); chk("t6_pend_w", 32'(pending), 32'h4);
    cfg_wr = 1'b0;
    step(); chk("t6_pend_a", 32'(pending), 32'h0);
    en = 4'b0100;
    step(); chk("t6_div_e1", 32'(div_out), 32'h4); chk("t6_tick_e1", 32'(tick_out), 32'h4);
    cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd7;
    step(); chk("t6_div_e2", 32'(div_out), 32'h4); chk("t6_tick_e2", 32'(tick_out), 32'h0);
    chk("t6_pend_e2", 32'(pending), 32'h4);
    chk("t6_ack_e2",  32'(cfg_ack), 32'h1);
    cfg_wr = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_div",  32'(div_out),  32'h0);
    chk("t6_rst_tick", 32'(tick_out), 32'h0);
    chk("t6_rst_pend", 32'(pending),  32'h0);
    chk("t6_rst_ack",  32'(cfg_ack),  32'h0);
    #2;
    rst = 1'b1;
    step(); chk("t6_div_r1", 32'(div_out), 32'h4); chk("t6_tick_r1", 32'(tick_out), 32'h4);
    step(); chk("t6_div_r2", 32'(div_out), 32'h0); chk("t6_tick_r2", 32'(tick_out), 32'h0);
    step(); chk("t6_div_r3", 32'(div_out), 32'h4); chk("t6_tick_r3", 32'(tick_out), 32'h4);
    step(); chk("t6_div_r4", 32'(div_out), 32'h0); chk("t6_tick_r4", 32'(tick_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
